// File: rtl/stack_alu_seq.sv
// Clocked stack-machine ALU: RPN binary ops over a DEPTH-entry stack, valid/ready
// command input, single-cycle ops plus an iterative WIDTH-cycle signed multiply.
module stack_alu_seq #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [2:0]                     opcode,
  input  logic [WIDTH-1:0]               input_data,
  output logic                           out_valid,
  output logic [WIDTH-1:0]               out_data,
  output logic                           overflow,
  output logic                           error,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic [1:0]                     dbg_state
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IW = $clog2(WIDTH + 1);
  localparam int PW = 2 * WIDTH;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_DUP   = 3'b010;
  localparam logic [2:0] OP_CLEAR = 3'b011;
  localparam logic [2:0] OP_ADD   = 3'b100;
  localparam logic [2:0] OP_MUL   = 3'b101;
  localparam logic [2:0] OP_PUSH  = 3'b110;
  localparam logic [2:0] OP_POP   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [WIDTH-1:0] r_stack [DEPTH];
  logic [CW-1:0]    r_count;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_overflow;
  logic             r_error;

  logic [PW-1:0]    r_acc;
  logic [PW-1:0]    r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [IW-1:0]    r_iter;

  // Handshake: a command transfers on a rising edge where in_valid && in_ready;
  // while in_ready is low the source holds opcode/input_data stable.
  logic w_in_ready;
  logic w_accept;
  assign w_in_ready = (r_state != S_MUL);
  assign w_accept   = in_valid && w_in_ready;

  logic [AW-1:0]    w_tos_idx;
  logic [AW-1:0]    w_nos_idx;
  logic [AW-1:0]    w_push_idx;
  logic [WIDTH-1:0] w_tos;
  logic [WIDTH-1:0] w_nos;
  logic             w_empty;
  logic             w_full;
  logic             w_lt2;

  assign w_tos_idx  = AW'(r_count - CW'(1));
  assign w_nos_idx  = AW'(r_count - CW'(2));
  assign w_push_idx = AW'(r_count);
  assign w_tos      = r_stack[w_tos_idx];
  assign w_nos      = r_stack[w_nos_idx];
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CW'(DEPTH));
  assign w_lt2      = (r_count < CW'(2));

  logic [WIDTH-1:0] w_add;
  logic [WIDTH-1:0] w_sub;
  logic             w_add_ovf;
  logic             w_sub_ovf;

  assign w_add     = w_nos + w_tos;
  assign w_sub     = w_nos - w_tos;
  assign w_add_ovf = (w_nos[WIDTH-1] == w_tos[WIDTH-1]) && (w_add[WIDTH-1] != w_nos[WIDTH-1]);
  assign w_sub_ovf = (w_nos[WIDTH-1] != w_tos[WIDTH-1]) && (w_sub[WIDTH-1] != w_nos[WIDTH-1]);

  // Command decode, meaningful only when the command is accepted.
  logic             w_emit;
  logic [WIDTH-1:0] w_res;
  logic             w_ovf;
  logic             w_err;
  logic             w_we;
  logic [AW-1:0]    w_widx;
  logic [CW-1:0]    w_count_next;
  logic             w_start_mul;

  always_comb begin
    w_emit       = 1'b0;
    w_res        = '0;
    w_ovf        = 1'b0;
    w_err        = 1'b0;
    w_we         = 1'b0;
    w_widx       = '0;
    w_count_next = r_count;
    w_start_mul  = 1'b0;
    case (opcode)
      OP_SUB, OP_ADD: begin
        w_emit = 1'b1;
        if (w_lt2) begin
          w_err = 1'b1;
        end else begin
          w_res        = (opcode == OP_ADD) ? w_add : w_sub;
          w_ovf        = (opcode == OP_ADD) ? w_add_ovf : w_sub_ovf;
          w_we         = 1'b1;
          w_widx       = w_nos_idx;
          w_count_next = r_count - CW'(1);
        end
      end
      OP_DUP: begin
        w_emit = 1'b1;
        if (w_empty || w_full) begin
          w_err = 1'b1;
        end else begin
          w_res        = w_tos;
          w_we         = 1'b1;
          w_widx       = w_push_idx;
          w_count_next = r_count + CW'(1);
        end
      end
      OP_CLEAR: begin
        w_emit       = 1'b1;
        w_count_next = '0;
      end
      OP_MUL: begin
        if (w_lt2) begin
          w_emit = 1'b1;
          w_err  = 1'b1;
        end else begin
          w_start_mul = 1'b1;
        end
      end
      OP_PUSH: begin
        w_emit = 1'b1;
        if (w_full) begin
          w_err = 1'b1;
        end else begin
          w_res        = input_data;
          w_we         = 1'b1;
          w_widx       = w_push_idx;
          w_count_next = r_count + CW'(1);
        end
      end
      OP_POP: begin
        w_emit = 1'b1;
        if (w_empty) begin
          w_err = 1'b1;
        end else begin
          w_res        = w_tos;
          w_count_next = r_count - CW'(1);
        end
      end
      default: begin
      end
    endcase
  end

  // Shift-add signed multiply: the multiplier's sign bit carries weight -2^(WIDTH-1),
  // so the final iteration subtracts the shifted multiplicand instead of adding it.
  logic          w_mul_last;
  logic          w_mul_fin;
  logic [PW-1:0] w_addend;
  logic [PW-1:0] w_acc_next;
  logic [WIDTH:0] w_prod_hi;
  logic          w_mul_ovf;

  assign w_mul_last = (r_iter == IW'(WIDTH - 1));
  assign w_mul_fin  = (r_state == S_MUL) && w_mul_last;
  assign w_addend   = r_mplier[0] ? (w_mul_last ? (~r_mcand + PW'(1)) : r_mcand) : '0;
  assign w_acc_next = r_acc + w_addend;
  assign w_prod_hi  = w_acc_next[PW-1:WIDTH-1];
  assign w_mul_ovf  = !((&w_prod_hi) || !(|w_prod_hi));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: w_state_next = (w_accept && w_start_mul) ? S_MUL : S_IDLE;
      S_MUL:          w_state_next = w_mul_last ? S_DONE : S_MUL;
      default:        w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  logic             w_stk_we;
  logic [AW-1:0]    w_stk_idx;
  logic [WIDTH-1:0] w_stk_data;

  assign w_stk_we   = (w_accept && w_we) || w_mul_fin;
  assign w_stk_idx  = w_mul_fin ? w_nos_idx : w_widx;
  assign w_stk_data = w_mul_fin ? w_acc_next[WIDTH-1:0] : w_res;

  // Entry contents are don't-care until written; only count is reset.
  always_ff @(posedge clk) begin
    if (w_stk_we) r_stack[w_stk_idx] <= w_stk_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_overflow  <= 1'b0;
      r_error     <= 1'b0;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_iter      <= '0;
    end else begin
      r_out_valid <= 1'b0;
      if (w_accept) begin
        r_count <= w_count_next;
        if (w_emit) begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_res;
          r_overflow  <= w_ovf;
          r_error     <= w_err;
        end
        if (w_start_mul) begin
          r_mcand  <= {{WIDTH{w_nos[WIDTH-1]}}, w_nos};
          r_mplier <= w_tos;
          r_acc    <= '0;
          r_iter   <= '0;
        end
      end else if (r_state == S_MUL) begin
        r_acc    <= w_acc_next;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_iter   <= r_iter + IW'(1);
        if (w_mul_last) begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_acc_next[WIDTH-1:0];
          r_overflow  <= w_mul_ovf;
          r_error     <= 1'b0;
          r_count     <= r_count - CW'(1);
        end
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign overflow  = r_overflow;
  assign error     = r_error;
  assign count     = r_count;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_stack_alu_seq.sv
// Bench for stack_alu_seq: directed scenarios then random commands, checked by a
// queue-based stack model through an expected-result scoreboard.
module tb_stack_alu_seq;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int MAXV  = (1 << (WIDTH - 1)) - 1;
  localparam int MINV  = -(1 << (WIDTH - 1));

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       opcode = 3'd0;
  logic [WIDTH-1:0] input_data = '0;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             overflow;
  logic             error;
  logic [CW-1:0]    count;
  logic [1:0]       dbg_state;

  stack_alu_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .opcode     (opcode),
    .input_data (input_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .overflow   (overflow),
    .error      (error),
    .count      (count),
    .dbg_state  (dbg_state)
  );

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             ovf;
    logic             err;
    int               cnt;
    int               cyc;
  } exp_t;

  exp_t exp_q[$];
  int   model_stk[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int sx(input logic [WIDTH-1:0] v);
    return int'($signed(v));
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: applies one accepted command to the stack queue and
  // queues the response expected at cycle acc (+WIDTH for a multiply).
  task automatic model(input logic [2:0] op, input logic [WIDTH-1:0] d, input int acc);
    exp_t e;
    bit   emit;
    int   a, b, r, lat;
    emit  = 1'b1;
    lat   = 1;
    e.data = '0;
    e.ovf  = 1'b0;
    e.err  = 1'b0;
    case (op)
      3'b000: emit = 1'b0;
      3'b001, 3'b100, 3'b101: begin
        if (model_stk.size() < 2) begin
          e.err = 1'b1;
        end else begin
          b = model_stk.pop_back();
          a = model_stk.pop_back();
          r = (op == 3'b001) ? a - b : (op == 3'b100) ? a + b : a * b;
          e.ovf  = (r > MAXV) || (r < MINV);
          e.data = WIDTH'(r);
          model_stk.push_back(sx(WIDTH'(r)));
          if (op == 3'b101) lat = WIDTH + 1;
        end
      end
      3'b010: begin
        if (model_stk.size() == 0 || model_stk.size() == DEPTH) begin
          e.err = 1'b1;
        end else begin
          e.data = WIDTH'(model_stk[model_stk.size() - 1]);
          model_stk.push_back(model_stk[model_stk.size() - 1]);
        end
      end
      3'b011: model_stk.delete();
      3'b110: begin
        if (model_stk.size() == DEPTH) begin
          e.err = 1'b1;
        end else begin
          e.data = d;
          model_stk.push_back(sx(d));
        end
      end
      default: begin
        if (model_stk.size() == 0) begin
          e.err = 1'b1;
        end else begin
          e.data = WIDTH'(model_stk.pop_back());
        end
      end
    endcase
    e.cnt = model_stk.size();
    e.cyc = acc + lat - 1;
    if (emit) exp_q.push_back(e);
  endtask

  // Driver: called at a falling edge; holds the command until in_ready is seen.
  task automatic send(input logic [2:0] op, input logic [WIDTH-1:0] d);
    int guard;
    in_valid   = 1'b1;
    opcode     = op;
    input_data = d;
    guard      = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: in_ready still %0b after %0d cycles", in_ready, guard);
      in_valid = 1'b0;
    end else begin
      model(op, d, cyc + 1);
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  // Called at the falling edge right after a MUL is accepted.
  task automatic check_mul_busy();
    for (int i = 0; i < WIDTH; i++) begin
      check("in_ready_low_during_mul", in_ready, 0);
      @(negedge clk);
    end
    check("in_ready_after_mul", in_ready, 1);
  endtask

  // Monitor / scoreboard
  exp_t m_e;
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_out_valid: cycle=%0d data=%0d required no pulse", cyc, $signed(out_data));
      end else begin
        m_e = exp_q.pop_front();
        if (out_data !== m_e.data || overflow !== m_e.ovf || error !== m_e.err ||
            int'(count) != m_e.cnt || cyc != m_e.cyc) begin
          bad++;
          $display("FAIL result: got data=%0d ovf=%0b err=%0b count=%0d cycle=%0d, expected data=%0d ovf=%0b err=%0b count=%0d cycle=%0d",
                   $signed(out_data), overflow, error, count, cyc,
                   $signed(m_e.data), m_e.ovf, m_e.err, m_e.cnt, m_e.cyc);
        end
      end
    end
  end

  logic [WIDTH-1:0] rnd_d;
  int               sel, g;
  logic [2:0]       rnd_op;

  initial begin
    // reset
    repeat (2) @(negedge clk);
    check("reset_count", count, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_overflow", overflow, 0);
    check("reset_error", error, 0);
    rst = 1'b0;
    @(negedge clk);

    // basic add
    send(3'b110, 8'd5);
    send(3'b110, 8'd3);
    send(3'b100, 8'd0);
    send(3'b011, 8'd0);

    // overflowing add, then sub
    send(3'b110, 8'd100);
    send(3'b110, 8'd50);
    send(3'b100, 8'd0);
    send(3'b110, 8'hF9);
    send(3'b001, 8'd0);
    send(3'b011, 8'd0);

    // multiply, busy window, overflowing multiply
    send(3'b110, 8'hF4);
    send(3'b110, 8'd10);
    send(3'b101, 8'd0);
    check_mul_busy();
    send(3'b110, 8'd2);
    send(3'b101, 8'd0);
    send(3'b011, 8'd0);

    // capacity limits
    for (int i = 0; i < DEPTH; i++) send(3'b110, WIDTH'(i * 3 + 1));
    send(3'b110, 8'd1);
    send(3'b010, 8'd0);
    for (int i = 0; i < DEPTH + 1; i++) send(3'b111, 8'd0);
    for (int i = 0; i < DEPTH; i++) send(3'b110, WIDTH'(i + 100));
    send(3'b100, 8'd0);
    send(3'b011, 8'd0);

    // empty-stack errors, DUP and MUL chain
    send(3'b100, 8'd0);
    send(3'b101, 8'd0);
    send(3'b110, 8'd4);
    send(3'b010, 8'd0);
    send(3'b101, 8'd0);
    send(3'b011, 8'd0);

    // reset during multiply
    send(3'b110, 8'd7);
    send(3'b110, 8'd9);
    send(3'b101, 8'd0);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    model_stk.delete();
    #2;
    check("midmul_reset_count", count, 0);
    check("midmul_reset_out_valid", out_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("after_reset_in_ready", in_ready, 1);
    check("after_reset_count", count, 0);
    repeat (WIDTH + 3) @(negedge clk);

    // random commands
    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 99);
      if      (sel < 30) rnd_op = 3'b110;
      else if (sel < 40) rnd_op = 3'b111;
      else if (sel < 52) rnd_op = 3'b100;
      else if (sel < 64) rnd_op = 3'b001;
      else if (sel < 74) rnd_op = 3'b101;
      else if (sel < 82) rnd_op = 3'b010;
      else if (sel < 85) rnd_op = 3'b011;
      else if (sel < 89) rnd_op = 3'b000;
      else               rnd_op = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 9);
      if      (sel == 0) rnd_d = 8'h80;
      else if (sel == 1) rnd_d = 8'h7F;
      else if (sel == 2) rnd_d = 8'hFF;
      else               rnd_d = WIDTH'($urandom_range(0, 255));
      send(rnd_op, rnd_d);
      if ($urandom_range(0, 4) == 0) @(negedge clk);
    end

    // drain
    g = 0;
    while (exp_q.size() != 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    check("final_count", count, model_stk.size());
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
